// File: rtl/rgbw_frame_decoder_pkg.sv
// Shared definitions for the RGBW frame decoder: FSM state encoding,
// default frame sync marker and payload field positions.
package rgbw_frame_decoder_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_FIELDS = 2'd1,
      ST_CKSUM  = 2'd2
   } state_e;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;

   // Field order inside payload_out for the default 7-field frame
   localparam int FLD_LINT      = 0;
   localparam int FLD_COLOR_IDX = 1;
   localparam int FLD_R         = 2;
   localparam int FLD_G         = 3;
   localparam int FLD_B         = 4;
   localparam int FLD_W         = 5;
   localparam int FLD_MODE      = 6;

endpackage

// File: rtl/rgbw_frame_decoder_edge_sync.sv
// Brings the SPI receiver's byte-ready into the clk domain and produces a
// one-cycle accept pulse on its rising edge, together with the latched byte.
module rgbw_frame_decoder_edge_sync
   import rgbw_frame_decoder_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rdy,
   output logic [DATA_W-1:0] data_out,
   output logic              accept
);

   logic              rdy_latch_r;
   logic              rdy_prev_r;
   logic [DATA_W-1:0] data_r;

   // rdy synchroniser and data latch; the source holds data stable while rdy is high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_latch_r <= 1'b0;
         rdy_prev_r  <= 1'b0;
         data_r      <= {DATA_W{1'b0}};
      end else begin
         rdy_latch_r <= rdy;
         rdy_prev_r  <= rdy_latch_r;
         data_r      <= data_in;
      end
   end

   assign accept   = rdy_latch_r & ~rdy_prev_r;
   assign data_out = data_r;

endmodule

// File: rtl/rgbw_frame_decoder.sv
// Frames the SPI byte stream into sync + N_FIELDS payload fields + optional
// checksum, and commits the payload atomically to payload_out.
module rgbw_frame_decoder
   import rgbw_frame_decoder_pkg::*;
#(
   parameter int              DATA_W      = 8,
   parameter int              N_FIELDS    = 7,
   parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(DEF_SYNC_BYTE),
   parameter int              CKSUM_EN    = 1,
   parameter int              TIMEOUT_CYC = 4096
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_W-1:0]              buffRx_spi,
   input  logic                           rdy,
   output logic [N_FIELDS*DATA_W-1:0]     payload_out,
   output logic                           frame_strobe,
   output logic                           frame_err,
   output logic                           busy,
   output logic [$clog2(N_FIELDS+2)-1:0]  byte_cnt_out
);

   localparam int CNT_W  = $clog2(N_FIELDS + 2);
   localparam int IDX_W  = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
   localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int TO_LIM = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_FIELDS - 1);
   localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TO_LIM);
   localparam logic [IDLE_W-1:0] IDLE_MAX = {IDLE_W{1'b1}};

   logic [DATA_W-1:0]          data_s;
   logic                       accept_s;
   state_e                     state_r, state_n;
   logic [IDX_W-1:0]           idx_r, idx_n;
   logic [DATA_W-1:0]          sum_r, sum_n;
   logic [N_FIELDS*DATA_W-1:0] shadow_r, shadow_s;
   logic [N_FIELDS*DATA_W-1:0] payload_r;
   logic [IDLE_W-1:0]          idle_r;
   logic                       commit_s, err_s, timeout_s;
   logic                       strobe_r, err_r;
   logic [CNT_W-1:0]           cnt_s;

   rgbw_frame_decoder_edge_sync #(.DATA_W(DATA_W)) u_edge_sync (
      .clk      (clk),
      .reset    (reset),
      .data_in  (buffRx_spi),
      .rdy      (rdy),
      .data_out (data_s),
      .accept   (accept_s)
   );

   // Expiry is one cycle early so frame_err lands exactly TIMEOUT_CYC edges after the last accept
   assign timeout_s = (TIMEOUT_CYC > 0) && (state_r != ST_HUNT) && (idle_r >= IDLE_LIM);

   // Next-state, shadow write, running sum and commit/error decisions
   always_comb begin
      state_n  = state_r;
      idx_n    = idx_r;
      sum_n    = sum_r;
      shadow_s = shadow_r;
      commit_s = 1'b0;
      err_s    = 1'b0;
      case (state_r)
         ST_HUNT: begin
            if (accept_s && (data_s == SYNC_BYTE)) begin
               state_n = ST_FIELDS;
               idx_n   = {IDX_W{1'b0}};
               sum_n   = {DATA_W{1'b0}};
            end else begin
               state_n = ST_HUNT;
            end
         end
         ST_FIELDS: begin
            if (accept_s) begin
               shadow_s[int'(idx_r)*DATA_W +: DATA_W] = data_s;
               sum_n = sum_r + data_s;
               if (idx_r == IDX_LAST) begin
                  if (CKSUM_EN != 0) begin
                     state_n = ST_CKSUM;
                  end else begin
                     commit_s = 1'b1;
                     state_n  = ST_HUNT;
                  end
               end else begin
                  idx_n = idx_r + IDX_W'(1);
               end
            end else if (timeout_s) begin
               err_s   = 1'b1;
               state_n = ST_HUNT;
            end else begin
               state_n = ST_FIELDS;
            end
         end
         ST_CKSUM: begin
            if (accept_s) begin
               if (data_s == sum_r) begin
                  commit_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
               state_n = ST_HUNT;
            end else if (timeout_s) begin
               err_s   = 1'b1;
               state_n = ST_HUNT;
            end else begin
               state_n = ST_CKSUM;
            end
         end
         default: begin
            state_n = ST_HUNT;
         end
      endcase
   end

   // Frame state, shadow fields and committed outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_HUNT;
         idx_r     <= {IDX_W{1'b0}};
         sum_r     <= {DATA_W{1'b0}};
         shadow_r  <= {(N_FIELDS*DATA_W){1'b0}};
         payload_r <= {(N_FIELDS*DATA_W){1'b0}};
         strobe_r  <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r  <= state_n;
         idx_r    <= idx_n;
         sum_r    <= sum_n;
         shadow_r <= shadow_s;
         strobe_r <= commit_s;
         err_r    <= err_s;
         if (commit_s) begin
            payload_r <= shadow_s;
         end
      end
   end

   // Idle counter: saturating, cleared in HUNT and on every accept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_r <= {IDLE_W{1'b0}};
      end else if ((state_r == ST_HUNT) || accept_s) begin
         idle_r <= {IDLE_W{1'b0}};
      end else if (idle_r != IDLE_MAX) begin
         idle_r <= idle_r + IDLE_W'(1);
      end else begin
         idle_r <= idle_r;
      end
   end

   // Progress indicator: k+1 while awaiting field k, N_FIELDS+1 awaiting checksum
   always_comb begin
      cnt_s = {CNT_W{1'b0}};
      case (state_r)
         ST_FIELDS: cnt_s = CNT_W'(idx_r) + CNT_W'(1);
         ST_CKSUM:  cnt_s = CNT_W'(N_FIELDS + 1);
         default:   cnt_s = {CNT_W{1'b0}};
      endcase
   end

   assign payload_out  = payload_r;
   assign frame_strobe = strobe_r;
   assign frame_err    = err_r;
   assign busy         = (state_r != ST_HUNT);
   assign byte_cnt_out = cnt_s;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Directed and randomized checks of rgbw_frame_decoder in three configurations:
// defaults, short timeout, and 3 fields without checksum.
module tb_rgbw_frame_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  data = 8'h00;
   logic [2:0]  rdy_v = 3'b000;

   logic [55:0] pay_a, pay_b;
   logic [23:0] pay_c;
   logic        strb_a, strb_b, strb_c, err_a, err_b, err_c;
   logic        busy_a, busy_b, busy_c;
   logic [3:0]  cnt_a, cnt_b;
   logic [2:0]  cnt_c;

   int n_cmp = 0;
   int n_bad = 0;
   int n_strb_a = 0, n_err_a = 0, n_strb_b = 0, n_err_b = 0, n_strb_c = 0;

   always #5 clk = ~clk;

   rgbw_frame_decoder u_dut_a (
      .clk(clk), .reset(reset), .buffRx_spi(data), .rdy(rdy_v[0]),
      .payload_out(pay_a), .frame_strobe(strb_a), .frame_err(err_a),
      .busy(busy_a), .byte_cnt_out(cnt_a));

   rgbw_frame_decoder #(.TIMEOUT_CYC(64)) u_dut_b (
      .clk(clk), .reset(reset), .buffRx_spi(data), .rdy(rdy_v[1]),
      .payload_out(pay_b), .frame_strobe(strb_b), .frame_err(err_b),
      .busy(busy_b), .byte_cnt_out(cnt_b));

   rgbw_frame_decoder #(.N_FIELDS(3), .CKSUM_EN(0)) u_dut_c (
      .clk(clk), .reset(reset), .buffRx_spi(data), .rdy(rdy_v[2]),
      .payload_out(pay_c), .frame_strobe(strb_c), .frame_err(err_c),
      .busy(busy_c), .byte_cnt_out(cnt_c));

   // Pulse counters sampled away from the active edge
   always @(negedge clk) begin
      if (strb_a) n_strb_a++;
      if (err_a)  n_err_a++;
      if (strb_b) n_strb_b++;
      if (err_b)  n_err_b++;
      if (strb_c) n_strb_c++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One byte per SPI transfer: rdy high 3 clk, low 3 clk
   task automatic send(input int which, input logic [7:0] b);
      @(negedge clk);
      data = b;
      rdy_v[which] = 1'b1;
      repeat (3) @(negedge clk);
      rdy_v[which] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   // Sync + 7 fields + checksum; a bad frame gets a corrupted checksum
   task automatic send_frame(input int which, input logic [55:0] f, input logic bad);
      logic [7:0] s;
      logic [7:0] flip;
      s = 8'h00;
      for (int k = 0; k < 7; k++) s = s + f[k*8 +: 8];
      flip = 8'($urandom_range(1, 255));
      send(which, 8'h55);
      for (int k = 0; k < 7; k++) send(which, f[k*8 +: 8]);
      send(which, bad ? (s ^ flip) : s);
   endtask

   initial begin
      logic [55:0] exp_pay;
      logic [55:0] f;
      logic [7:0]  s;
      logic [7:0]  junk;
      logic        bad;
      int          st0, er0, first;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_payload", {8'h00, pay_a}, 64'h0);
      chk("rst_strobe", {63'h0, strb_a}, 64'h0);
      chk("rst_err", {63'h0, err_a}, 64'h0);
      chk("rst_busy", {63'h0, busy_a}, 64'h0);
      chk("rst_cnt", {60'h0, cnt_a}, 64'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // Known good frame
      st0 = n_strb_a; er0 = n_err_a;
      send_frame(0, 56'h01_20_40_80_FF_02_10, 1'b0);
      exp_pay = 56'h01_20_40_80_FF_02_10;
      chk("t1_strobes", 64'(n_strb_a - st0), 64'd1);
      chk("t1_errs", 64'(n_err_a - er0), 64'd0);
      chk("t1_payload", {8'h00, pay_a}, {8'h00, exp_pay});

      // Same fields, wrong checksum
      st0 = n_strb_a; er0 = n_err_a;
      send(0, 8'h55);
      for (int k = 0; k < 7; k++) send(0, exp_pay[k*8 +: 8]);
      send(0, 8'h00);
      chk("t2_strobes", 64'(n_strb_a - st0), 64'd0);
      chk("t2_errs", 64'(n_err_a - er0), 64'd1);
      chk("t2_payload", {8'h00, pay_a}, {8'h00, exp_pay});

      // Leading junk, byte counter progression
      st0 = n_strb_a;
      send(0, 8'h00);
      chk("t3_cnt_junk0", {60'h0, cnt_a}, 64'd0);
      send(0, 8'hAA);
      chk("t3_cnt_junk1", {60'h0, cnt_a}, 64'd0);
      send(0, 8'h55);
      chk("t3_cnt_sync", {60'h0, cnt_a}, 64'd1);
      s = 8'h00;
      for (int k = 0; k < 7; k++) begin
         f[k*8 +: 8] = 8'($urandom);
         s = s + f[k*8 +: 8];
         send(0, f[k*8 +: 8]);
         chk($sformatf("t3_cnt_f%0d", k), {60'h0, cnt_a}, 64'(k + 2));
      end
      send(0, s);
      chk("t3_cnt_done", {60'h0, cnt_a}, 64'd0);
      chk("t3_strobes", 64'(n_strb_a - st0), 64'd1);
      exp_pay = f;
      chk("t3_payload", {8'h00, pay_a}, {8'h00, exp_pay});

      // Randomized frames with junk and occasional bad checksums
      for (int i = 0; i < 16; i++) begin
         st0 = n_strb_a; er0 = n_err_a;
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            junk = 8'($urandom);
            if (junk == 8'h55) junk = 8'h54;
            send(0, junk);
         end
         for (int k = 0; k < 7; k++) f[k*8 +: 8] = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         send_frame(0, f, bad);
         if (!bad) exp_pay = f;
         chk($sformatf("rnd%0d_strobes", i), 64'(n_strb_a - st0), bad ? 64'd0 : 64'd1);
         chk($sformatf("rnd%0d_errs", i), 64'(n_err_a - er0), bad ? 64'd1 : 64'd0);
         chk($sformatf("rnd%0d_payload", i), {8'h00, pay_a}, {8'h00, exp_pay});
      end

      // Timeout after a partial frame (64 idle cycles)
      er0 = n_err_b;
      send(1, 8'h55);
      send(1, 8'h11);
      send(1, 8'h22);
      chk("t4_busy_mid", {63'h0, busy_b}, 64'd1);
      first = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (err_b && first < 0) first = i;
         if (first >= 0) break;
      end
      chk("t4_err_timing", {63'h0, (first >= 58 && first <= 62)}, 64'd1);
      @(negedge clk);
      #1;
      chk("t4_err_count", 64'(n_err_b - er0), 64'd1);
      chk("t4_busy_after", {63'h0, busy_b}, 64'd0);
      chk("t4_payload_kept", {8'h00, pay_b}, 64'h0);
      st0 = n_strb_b;
      f = 56'h0D_0C_0B_0A_09_08_07;
      send_frame(1, f, 1'b0);
      chk("t4_next_strobe", 64'(n_strb_b - st0), 64'd1);
      chk("t4_next_payload", {8'h00, pay_b}, {8'h00, f});

      // 3 fields, no checksum, strobe exactly one cycle after the last accept
      st0 = n_strb_c;
      send(2, 8'h55);
      send(2, 8'h01);
      send(2, 8'h02);
      @(negedge clk);
      data = 8'h03;
      rdy_v[2] = 1'b1;
      @(negedge clk);
      chk("t5_strobe_early", {63'h0, strb_c}, 64'd0);
      @(negedge clk);
      chk("t5_strobe_on", {63'h0, strb_c}, 64'd1);
      @(negedge clk);
      chk("t5_strobe_off", {63'h0, strb_c}, 64'd0);
      rdy_v[2] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("t5_payload", {40'h0, pay_c}, 64'h030201);
      chk("t5_strobes", 64'(n_strb_c - st0), 64'd1);
      chk("t5_err", {63'h0, err_c}, 64'd0);

      // Async reset in the middle of a frame
      send(0, 8'h55);
      send(0, 8'h12);
      send(0, 8'h34);
      chk("t6_busy_pre", {63'h0, busy_a}, 64'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_payload_rst", {8'h00, pay_a}, 64'h0);
      chk("t6_busy_rst", {63'h0, busy_a}, 64'd0);
      chk("t6_cnt_rst", {60'h0, cnt_a}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      st0 = n_strb_a;
      for (int k = 0; k < 7; k++) f[k*8 +: 8] = 8'($urandom);
      send_frame(0, f, 1'b0);
      chk("t6_strobes", 64'(n_strb_a - st0), 64'd1);
      chk("t6_payload", {8'h00, pay_a}, {8'h00, f});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
